// File: rtl/dmem_responder.sv
// Data-memory responder: serialized load/store requests, fixed-latency array access,
// load data returned over a valid/ready response handshake.
module dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        rsp_err,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int          DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_cnt;
    logic                    r_is_load;
    logic                    r_fault;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic                    r_rsp_err;
    logic                    r_err;
    logic [31:0]             r_mem [DEPTH];

    logic w_accept, w_illegal, w_access, w_fault, w_done;

    // Acceptance uses the state only; rst already forces the state to IDLE.
    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_illegal = MemRead && MemWrite;
    assign w_access  = MemRead ^ MemWrite;
    assign w_fault   = (addr[1:0] != 2'b00) || (addr[31:ADDR_WIDTH+2] != '0);
    assign w_done    = (r_state == ACCESS) && (r_cnt == 4'd0);

    assign req_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rdata     = r_rdata;
    assign rsp_err   = r_rsp_err;
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_access) w_state_nxt = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_state_nxt = r_is_load ? RESP : IDLE;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_is_load <= 1'b0;
            r_fault   <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_rsp_err <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && (w_illegal || (w_access && w_fault));
            if (w_accept && w_access) begin
                r_cnt     <= LAT_M1;
                r_is_load <= MemRead;
                r_fault   <= w_fault;
                r_idx     <= addr[ADDR_WIDTH+1:2];
                r_wdata   <= wdata;
            end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done && r_is_load) begin
                r_rdata   <= r_fault ? 32'h0 : r_mem[r_idx];
                r_rsp_err <= r_fault;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rdata   <= 32'h0;
                r_rsp_err <= 1'b0;
            end
        end
    end

    // Array is never reset; a faulted store is dropped.
    always_ff @(posedge clk) begin
        if (w_done && !r_is_load && !r_fault) r_mem[r_idx] <= r_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_WIDTH=8, LATENCY=2).
module tb_dmem_responder;

    logic        clk, rst;
    logic        req_valid, req_ready, MemRead, MemWrite;
    logic [31:0] addr, wdata, rdata;
    logic        rsp_valid, rsp_ready, rsp_err, err, busy;

    int n_cmp = 0;
    int n_err = 0;

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata(rdata),
        .rsp_err(rsp_err), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request; returns 1ns after its acceptance edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        tick();
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        req(1'b0, 1'b1, a, d);
        tick(); tick();
        chk("store_done_ready", {31'b0, req_ready}, 32'd1);
    endtask

    // Load with rsp_ready high: response after N+2, handshake at N+3.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_e);
        rsp_ready = 1'b1;
        req(1'b1, 1'b0, a, 32'h0);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_e});
        tick(); tick();
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, rdata, exp_d);
        chk({tag, "_rsp_err"}, {31'b0, rsp_err}, {31'b0, exp_e});
        tick();
        chk({tag, "_hs_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_hs_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    logic [31:0] bd [4];
    int waits, got, expw;

    initial begin
        bd[0] = 32'h11111111; bd[1] = 32'h22222222; bd[2] = 32'h33333333; bd[3] = 32'h44444444;
        rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr = 32'h0; wdata = 32'h0; rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // Store then load with a 5-cycle consumer stall.
        req(1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
        chk("st_busy", {31'b0, busy}, 32'd1);
        chk("st_ready_e1", {31'b0, req_ready}, 32'd0);
        tick();
        chk("st_ready_e2", {31'b0, req_ready}, 32'd0);
        tick();
        chk("st_ready_e3", {31'b0, req_ready}, 32'd1);
        chk("st_idle", {31'b0, busy}, 32'd0);
        req(1'b1, 1'b0, 32'h10, 32'h0);
        chk("ld_valid_n", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("ld_valid_n1", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("ld_valid_n2", {31'b0, rsp_valid}, 32'd1);
        chk("ld_rdata", rdata, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_rdata", rdata, 32'hCAFEF00D);
            chk("stall_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("hs_valid", {31'b0, rsp_valid}, 32'd0);
        chk("hs_rdata", rdata, 32'h0);
        chk("hs_ready", {31'b0, req_ready}, 32'd1);

        // Faults: misaligned store is dropped, out-of-range load errors.
        req(1'b0, 1'b1, 32'h13, 32'hDEADBEEF);
        chk("mis_err", {31'b0, err}, 32'd1);
        chk("mis_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("mis_err_pulse", {31'b0, err}, 32'd0);
        tick();
        do_load("reload10", 32'h10, 32'hCAFEF00D, 1'b0);
        do_load("oor", 32'h400, 32'h0, 1'b1);

        // Illegal and nop requests.
        req(1'b1, 1'b1, 32'h10, 32'h0);
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("ill_err_pulse", {31'b0, err}, 32'd0);
        chk("ill_no_rsp", {31'b0, rsp_valid}, 32'd0);
        req(1'b0, 1'b0, 32'h13, 32'h0);
        chk("nop_err", {31'b0, err}, 32'd0);
        chk("nop_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("nop_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // Reset aborts a pending store.
        do_store(32'h20, 32'h0);
        req(1'b0, 1'b1, 32'h20, 32'h12345678);
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'b0, req_ready}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        do_load("abort_reload", 32'h20, 32'h0, 1'b0);

        // Reset discards a pending load response.
        rsp_ready = 1'b0;
        req(1'b1, 1'b0, 32'h10, 32'h0);
        tick(); tick();
        chk("disc_pre_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("disc_valid", {31'b0, rsp_valid}, 32'd0);
        chk("disc_rdata", rdata, 32'h0);
        chk("disc_busy", {31'b0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("disc_ready", {31'b0, req_ready}, 32'd1);

        // Back-to-back with req_valid held high: stores every 3 edges, loads every 4.
        got = 0;
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            MemWrite = (k < 4); MemRead = (k >= 4);
            addr = 32'((k % 4) * 4); wdata = bd[k % 4];
            waits = 0;
            while (!req_ready && waits < 20) begin
                if (rsp_valid) begin
                    chk("b2b_rdata", rdata, bd[got % 4]);
                    got++;
                end
                tick();
                waits++;
            end
            expw = (k == 0) ? 0 : ((k <= 4) ? 2 : 3);
            chk("b2b_wait", waits, expw);
            tick();
        end
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        waits = 0;
        while (!rsp_valid && waits < 20) begin
            tick();
            waits++;
        end
        chk("b2b_last_valid", {31'b0, rsp_valid}, 32'd1);
        chk("b2b_last_rdata", rdata, bd[3]);
        got++;
        chk("b2b_count", got, 32'd4);
        tick();
        chk("b2b_end_ready", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
